dds_fcw_sweep_ctrl: RTL and testbench
=====================================

// Module: dds_fcw_sweep_ctrl
// PURPOSE
//  Avalon-MM-configured sequencer that drives the DDS frequency control word (FCW).
//  Software programs start/stop/step/dwell, then the block steps fcw_out autonomously.
//  Supports single or continuous sweeps, abort, and a manual FCW load while idle.
//  Sits between the Nios/UART command path and the phase accumulator, replacing the plain FCW PIO.
// PARAMETERS
//  FCW_W    8   width of the FCW and of the START/STOP/STEP/MANUAL registers
//  DWELL_W  16  width of the dwell counter and the DWELL register
// PORTS
//  clk        in   1       system clock
//  reset_n    in   1       asynchronous active-low reset
//  address    in   3       Avalon register index
//  chipselect in   1       Avalon select
//  write_n    in   1       Avalon write strobe, active low
//  writedata  in   32      Avalon write data
//  readdata   out  32      Avalon read data; combinational, zero-extended, unmapped = 0
//  fcw_out    out  FCW_W   FCW to the phase accumulator (registered)
//  fcw_valid  out  1       1-cycle pulse on every fcw_out update
//  busy       out  1       1 while a sweep is running
//  irq        out  1       done & CTRL.irq_en (level)
// BEHAVIOUR
//  Interface: one clock (clk); reset_n is asynchronous, active low.
//  Reset: every register, fcw_out, fcw_valid, busy, done and irq = 0; state IDLE.
//  Register map (write = chipselect & ~write_n):
//   0 CTRL   b0 start (W1, self-clearing), b1 continuous, b2 abort (W1), b3 irq_en; reads b1,b3
//   1 START  2 STOP  3 STEP  (FCW_W bits)   4 DWELL (DWELL_W bits)
//   5 STATUS b0 busy (RO), b1 done (sticky, write 1 to clear)   6 CUR (RO, = fcw_out)
//   7 MANUAL write while IDLE: fcw_out <= writedata, fcw_valid pulses next cycle; ignored while RUN
//  FSM: IDLE, RUN.
//   IDLE -> RUN on the edge that accepts CTRL.start: START/STOP/STEP/DWELL/continuous copied to
//    shadow regs; fcw_out <= START; dwell_cnt <= DWELL; fcw_valid = 1 the following cycle; done cleared.
//   RUN: dwell_cnt != 0 -> decrement. dwell_cnt == 0 -> end of point:
//    fcw_out != STOP -> fcw_out <= next, dwell_cnt <= DWELL, fcw_valid pulse.
//    fcw_out == STOP, single     -> IDLE, done <= 1, fcw_out holds STOP, no pulse.
//    fcw_out == STOP, continuous -> fcw_out <= START, dwell_cnt <= DWELL, fcw_valid pulse.
//   Each point is held DWELL+1 cycles; DWELL = 0 gives one point per clock.
//  Next-point arithmetic (FCW_W+1 bit, on shadow values):
//   up (START <= STOP): next = cur+STEP; if next > STOP (incl. carry out) next = STOP.
//   down (START > STOP): next = cur-STEP; if next < STOP (incl. borrow) next = STOP.
//   STEP == 0 is treated as 1. START == STOP: single point, then done (or repeat).
//  Simultaneous events:
//   abort (any cycle in RUN) -> IDLE next edge, fcw_out holds, no done, no pulse; abort wins over start.
//   start while RUN ignored. Config writes during RUN update regs only; take effect on next start.
//   done-clear and done-set in same cycle: set wins.
//  irq = done & irq_en; clearing done deasserts irq next cycle.
//  Reset mid-sweep: immediate return to reset values; fcw_out = 0.
// TESTING
//  T1 START=10 STOP=40 STEP=10 DWELL=2 single -> fcw_out 10,20,30,40, each held 3 cycles;
//     4 fcw_valid pulses; done=1 and busy=0 3 cycles after 40 appears
//  T2 clamp: START=10 STOP=35 STEP=10 -> 10,20,30,35; up carry: START=200 STOP=255 STEP=100 -> 200,255
//  T3 down: START=250 STOP=5 STEP=100 DWELL=0 -> 250,150,50,5 on consecutive cycles, then done
//  T4 continuous START=1 STOP=3 STEP=1 DWELL=0 -> 1,2,3,1,2,3...; abort at value 2 -> holds 2,
//     busy=0, done=0; start while RUN and STEP writes mid-sweep have no visible effect until restart
//  T5 MANUAL=0x55 in IDLE -> fcw_out=0x55 with 1 pulse; MANUAL during RUN -> ignored
//  T6 reset_n low mid-sweep (async, between edges) -> fcw_out=0, busy=0, readdata of all regs = 0;
//     irq_en=1 single sweep -> irq=1 at done; STATUS write 0x2 -> irq=0

Source files
------------

// File: rtl/dds_fcw_sweep_ctrl_if.sv
// rtl/dds_fcw_sweep_ctrl_if.sv - Avalon-MM register port bundle for the FCW sweep controller
interface dds_fcw_sweep_ctrl_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );
endinterface

// File: rtl/dds_fcw_sweep_ctrl.sv
// rtl/dds_fcw_sweep_ctrl.sv - Avalon-MM programmed DDS frequency-word sweep sequencer
// Steps fcw_out from START to STOP by STEP, holding each point DWELL+1 cycles.
module dds_fcw_sweep_ctrl #(
  parameter int FCW_W   = 8,
  parameter int DWELL_W = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  dds_fcw_sweep_ctrl_if.slave  bus,
  output logic [FCW_W-1:0]     fcw_out,
  output logic                 fcw_valid,
  output logic                 busy,
  output logic                 irq
);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t               r_state, w_state_nxt;

  logic [FCW_W-1:0]     r_start_cfg, r_stop_cfg, r_step_cfg;
  logic [DWELL_W-1:0]   r_dwell_cfg;
  logic                 r_cont_cfg, r_irq_en;

  logic [FCW_W-1:0]     r_start_sh, r_stop_sh, r_step_sh;
  logic [DWELL_W-1:0]   r_dwell_sh;
  logic                 r_cont_sh;

  logic [FCW_W-1:0]     r_fcw, w_fcw_nxt;
  logic                 r_fcw_valid, w_valid_nxt;
  logic [DWELL_W-1:0]   r_cnt, w_cnt_nxt;
  logic                 r_done, w_done_set, w_load_shadow;

  logic                 w_wr, w_start, w_abort, w_manual, w_done_clr;
  logic                 w_up;
  logic [FCW_W-1:0]     w_step_eff, w_next_pt;
  logic [FCW_W:0]       w_sum, w_diff;

  assign w_wr       = bus.chipselect & ~bus.write_n;
  assign w_abort    = w_wr && (bus.address == 3'd0) && bus.writedata[2];
  assign w_start    = w_wr && (bus.address == 3'd0) && bus.writedata[0] && !bus.writedata[2];
  assign w_manual   = w_wr && (bus.address == 3'd7);
  assign w_done_clr = w_wr && (bus.address == 3'd5) && bus.writedata[1];

  // Next point uses one extra bit so carry/borrow past the range end clamps to STOP.
  assign w_step_eff = (r_step_sh == '0) ? FCW_W'(1) : r_step_sh;
  assign w_up       = (r_start_sh <= r_stop_sh);
  assign w_sum      = {1'b0, r_fcw} + {1'b0, w_step_eff};
  assign w_diff     = {1'b0, r_fcw} - {1'b0, w_step_eff};

  always_comb begin
    w_next_pt = r_stop_sh;
    if (w_up) begin
      if (w_sum <= {1'b0, r_stop_sh})
        w_next_pt = w_sum[FCW_W-1:0];
    end else begin
      if (!w_diff[FCW_W] && (w_diff >= {1'b0, r_stop_sh}))
        w_next_pt = w_diff[FCW_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      r_state <= S_IDLE;
    else
      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_fcw_nxt     = r_fcw;
    w_valid_nxt   = 1'b0;
    w_cnt_nxt     = r_cnt;
    w_done_set    = 1'b0;
    w_load_shadow = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          w_state_nxt   = S_RUN;
          w_load_shadow = 1'b1;
          w_fcw_nxt     = r_start_cfg;
          w_cnt_nxt     = r_dwell_cfg;
          w_valid_nxt   = 1'b1;
        end else if (w_manual) begin
          w_fcw_nxt   = bus.writedata[FCW_W-1:0];
          w_valid_nxt = 1'b1;
        end
      end
      S_RUN: begin
        if (w_abort) begin
          w_state_nxt = S_IDLE;
        end else if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - DWELL_W'(1);
        end else if (r_fcw != r_stop_sh) begin
          w_fcw_nxt   = w_next_pt;
          w_cnt_nxt   = r_dwell_sh;
          w_valid_nxt = 1'b1;
        end else if (r_cont_sh) begin
          w_fcw_nxt   = r_start_sh;
          w_cnt_nxt   = r_dwell_sh;
          w_valid_nxt = 1'b1;
        end else begin
          w_state_nxt = S_IDLE;
          w_done_set  = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_start_cfg <= '0;
      r_stop_cfg  <= '0;
      r_step_cfg  <= '0;
      r_dwell_cfg <= '0;
      r_cont_cfg  <= 1'b0;
      r_irq_en    <= 1'b0;
    end else if (w_wr) begin
      case (bus.address)
        3'd0: begin
          r_cont_cfg <= bus.writedata[1];
          r_irq_en   <= bus.writedata[3];
        end
        3'd1: r_start_cfg <= bus.writedata[FCW_W-1:0];
        3'd2: r_stop_cfg  <= bus.writedata[FCW_W-1:0];
        3'd3: r_step_cfg  <= bus.writedata[FCW_W-1:0];
        3'd4: r_dwell_cfg <= bus.writedata[DWELL_W-1:0];
        default: ;
      endcase
    end
  end

  // Continuous comes from the start write itself, since CTRL carries both bits.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_start_sh <= '0;
      r_stop_sh  <= '0;
      r_step_sh  <= '0;
      r_dwell_sh <= '0;
      r_cont_sh  <= 1'b0;
    end else if (w_load_shadow) begin
      r_start_sh <= r_start_cfg;
      r_stop_sh  <= r_stop_cfg;
      r_step_sh  <= r_step_cfg;
      r_dwell_sh <= r_dwell_cfg;
      r_cont_sh  <= bus.writedata[1];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_fcw       <= '0;
      r_fcw_valid <= 1'b0;
      r_cnt       <= '0;
    end else begin
      r_fcw       <= w_fcw_nxt;
      r_fcw_valid <= w_valid_nxt;
      r_cnt       <= w_cnt_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      r_done <= 1'b0;
    else if (w_done_set)
      r_done <= 1'b1;
    else if (w_load_shadow || w_done_clr)
      r_done <= 1'b0;
  end

  always_comb begin
    bus.readdata = '0;
    case (bus.address)
      3'd0:    bus.readdata = {28'd0, r_irq_en, 1'b0, r_cont_cfg, 1'b0};
      3'd1:    bus.readdata = 32'(r_start_cfg);
      3'd2:    bus.readdata = 32'(r_stop_cfg);
      3'd3:    bus.readdata = 32'(r_step_cfg);
      3'd4:    bus.readdata = 32'(r_dwell_cfg);
      3'd5:    bus.readdata = {30'd0, r_done, (r_state == S_RUN)};
      3'd6:    bus.readdata = 32'(r_fcw);
      default: bus.readdata = '0;
    endcase
  end

  assign fcw_out   = r_fcw;
  assign fcw_valid = r_fcw_valid;
  assign busy      = (r_state == S_RUN);
  assign irq       = r_done & r_irq_en;

endmodule

// File: tb/tb_dds_fcw_sweep_ctrl.sv
// tb/tb_dds_fcw_sweep_ctrl.sv - scoreboard bench for dds_fcw_sweep_ctrl
// Expected FCW points come from a plain-integer sweep model and are checked by a monitor.
module tb_dds_fcw_sweep_ctrl;

  logic       clk;
  logic       reset_n;
  logic [7:0] fcw_out;
  logic       fcw_valid, busy, irq;

  dds_fcw_sweep_ctrl_if bus_if ();

  dds_fcw_sweep_ctrl #(.FCW_W(8), .DWELL_W(16)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus_if),
    .fcw_out   (fcw_out),
    .fcw_valid (fcw_valid),
    .busy      (busy),
    .irq       (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {int val; int gap;} exp_t;
  exp_t exp_q[$];
  int   end_q[$];
  int   model_pts[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc = 0;
  int   last_pulse = 0;
  logic prev_busy = 1'b0;

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s act=%0d required=%0d", name, act, req);
    end
  endtask

  // Sweep model: integer walk with clamp at STOP, STEP 0 behaves as 1.
  function automatic void gen_points(input int s, input int e, input int st);
    int p, se;
    model_pts.delete();
    se = (st == 0) ? 1 : st;
    p = s;
    model_pts.push_back(p);
    while (p != e) begin
      if (s <= e) begin
        p = p + se;
        if (p > e) p = e;
      end else begin
        p = p - se;
        if (p < e) p = e;
      end
      model_pts.push_back(p);
    end
  endfunction

  always @(negedge clk) begin : monitor
    exp_t e;
    cyc = cyc + 1;
    if (reset_n) begin
      if (fcw_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_pulse act=%0d required=none", fcw_out);
        end else begin
          e = exp_q.pop_front();
          chk("pulse_val", int'(fcw_out), e.val);
          if (e.gap >= 0) chk("pulse_gap", cyc - last_pulse, e.gap);
        end
        last_pulse = cyc;
      end
      if (prev_busy && !busy && end_q.size() > 0)
        chk("done_latency", cyc - last_pulse, end_q.pop_front());
    end
    prev_busy = busy;
  end

  task automatic bus_write(input int addr, input int data);
    @(posedge clk); #1;
    bus_if.address    = 3'(addr);
    bus_if.writedata  = data;
    bus_if.chipselect = 1'b1;
    bus_if.write_n    = 1'b0;
    @(posedge clk); #1;
    bus_if.chipselect = 1'b0;
    bus_if.write_n    = 1'b1;
  endtask

  task automatic bus_read(input int addr, output int data);
    @(posedge clk); #1;
    bus_if.address    = 3'(addr);
    bus_if.chipselect = 1'b1;
    bus_if.write_n    = 1'b1;
    @(negedge clk);
    data = int'(bus_if.readdata);
    bus_if.chipselect = 1'b0;
  endtask

  task automatic wait_idle(input int lim);
    for (int i = 0; i < lim; i++) begin
      @(posedge clk); #1;
      if (!busy) break;
    end
    chk("idle_timeout", int'(busy), 0);
  endtask

  task automatic push_single(input int s, input int e, input int st, input int d);
    gen_points(s, e, st);
    for (int i = 0; i < model_pts.size(); i++)
      exp_q.push_back('{val: model_pts[i], gap: (i == 0) ? -1 : d + 1});
    end_q.push_back(d + 1);
  endtask

  task automatic finish_single(input int stop, input int irq_en);
    int rd;
    wait_idle(model_pts.size() * 70000 + 20 > 60000 ? 60000 : model_pts.size() * 8 + 40);
    chk("points_seen", exp_q.size(), 0);
    bus_read(5, rd);
    chk("status_done", rd, 2);
    bus_read(6, rd);
    chk("cur_stop", rd, stop);
    chk("irq_at_done", int'(irq), irq_en);
    bus_write(5, 2);
    chk("irq_cleared", int'(irq), 0);
    bus_read(5, rd);
    chk("status_cleared", rd, 0);
  endtask

  task automatic run_single(input int s, input int e, input int st, input int d, input int irq_en);
    bus_write(1, s);
    bus_write(2, e);
    bus_write(3, st);
    bus_write(4, d);
    push_single(s, e, st, d);
    bus_write(0, (irq_en << 3) | 1);
    finish_single(e, irq_en);
  endtask

  initial begin
    int rd, s, e, st, d, ie;
    bus_if.address    = '0;
    bus_if.chipselect = 1'b0;
    bus_if.write_n    = 1'b1;
    bus_if.writedata  = '0;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    chk("rst_fcw", int'(fcw_out), 0);
    chk("rst_valid", int'(fcw_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_irq", int'(irq), 0);
    for (int a = 0; a < 8; a++) begin
      bus_read(a, rd);
      chk("rst_reg", rd, 0);
    end

    bus_write(0, 32'h0A);
    bus_read(0, rd);
    chk("ctrl_readback", rd, 32'h0A);
    bus_write(0, 0);

    run_single(10, 40, 10, 2, 0);
    run_single(10, 35, 10, 1, 1);
    run_single(200, 255, 100, 0, 0);
    run_single(250, 5, 100, 0, 1);
    run_single(7, 7, 3, 1, 0);
    run_single(5, 9, 0, 0, 0);

    for (int k = 0; k < 20; k++) begin
      s  = $urandom_range(0, 255);
      e  = $urandom_range(0, 255);
      st = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 255);
      d  = $urandom_range(0, 3);
      ie = $urandom_range(0, 1);
      run_single(s, e, st, d, ie);
    end

    // Continuous 1..3 with mid-sweep STEP write and ignored start, then abort at 2.
    bus_write(1, 1);
    bus_write(2, 3);
    bus_write(3, 1);
    bus_write(4, 0);
    for (int i = 0; i < 200; i++)
      exp_q.push_back('{val: (i % 3) + 1, gap: (i == 0) ? -1 : 1});
    bus_write(0, 3);
    bus_write(3, 2);
    bus_write(0, 3);
    repeat (4) @(posedge clk);
    #1;
    for (int i = 0; i < 20; i++) begin
      if (fcw_out == 8'd2) break;
      @(posedge clk); #1;
    end
    chk("cont_at_two", int'(fcw_out), 2);
    bus_if.address    = 3'd0;
    bus_if.writedata  = 32'h4;
    bus_if.chipselect = 1'b1;
    bus_if.write_n    = 1'b0;
    @(posedge clk); #1;
    bus_if.chipselect = 1'b0;
    bus_if.write_n    = 1'b1;
    exp_q.delete();
    chk("abort_busy", int'(busy), 0);
    chk("abort_hold", int'(fcw_out), 2);
    bus_read(5, rd);
    chk("abort_no_done", rd, 0);
    chk("abort_hold_later", int'(fcw_out), 2);

    push_single(1, 3, 2, 0);
    bus_write(0, 1);
    finish_single(3, 0);

    push_single(1, 1, 1, 0);
    model_pts.delete();
    exp_q.delete();
    end_q.delete();
    exp_q.push_back('{val: 8'h55, gap: -1});
    bus_write(7, 32'h55);
    chk("manual_idle", int'(fcw_out), 32'h55);
    repeat (2) @(posedge clk);
    chk("manual_pulse_seen", exp_q.size(), 0);

    bus_write(1, 10);
    bus_write(2, 20);
    bus_write(3, 10);
    bus_write(4, 5);
    push_single(10, 20, 10, 5);
    bus_write(0, 1);
    bus_write(7, 32'hAA);
    finish_single(20, 0);

    // Asynchronous reset between edges in the middle of a sweep.
    bus_write(1, 0);
    bus_write(2, 255);
    bus_write(3, 1);
    bus_write(4, 3);
    push_single(0, 255, 1, 3);
    bus_write(0, 32'h9);
    repeat (10) @(posedge clk);
    #1;
    exp_q.delete();
    end_q.delete();
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_fcw", int'(fcw_out), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_valid", int'(fcw_valid), 0);
    for (int a = 0; a < 8; a++) begin
      bus_read(a, rd);
      chk("mid_rst_reg", rd, 0);
    end
    @(posedge clk); #1 reset_n = 1'b1;

    run_single(3, 12, 4, 1, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL global_timeout act=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
